// File: rtl/miriscv_data_arb_if.sv
// Single data-memory protocol channel (request fields out, grant/response back).
// The master modport issues requests; the slave modport answers them.
interface miriscv_data_arb_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/miriscv_data_arb.sv
// Round-robin arbiter sharing one data-memory port between two masters, one transaction in flight.
// Optional response timeout compiled in with `define MIRISCV_DATA_ARB_TIMEOUT_EN.
module miriscv_data_arb #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 clk_i,
  input  logic                 arstn_i,
  miriscv_data_arb_if.slave    m0,
  miriscv_data_arb_if.slave    m1,
  miriscv_data_arb_if.master   data
`ifdef MIRISCV_DATA_ARB_TIMEOUT_EN
  ,
  output logic                 timeout_o
`endif
);

  typedef enum logic [1:0] {StIdle, StAddr, StResp} state_e;

  state_e      state_q;
  logic        owner_q;
  logic        last_owner_q;
  logic        req_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        winner;
  logic        gnt_hit;
  logic        rsp_hit;
  logic        abort;
  logic [31:0] rsp_rdata;

  // Tie goes to whichever master did not own the previous transaction.
  always_comb begin
    winner = 1'b0;
    if (m0.req && m1.req) begin
      winner = ~last_owner_q;
    end else begin
      winner = m1.req;
    end
  end

`ifdef MIRISCV_DATA_ARB_TIMEOUT_EN
  localparam logic [9:0] CntLast = 10'(TIMEOUT_CYCLES - 1);

  logic [9:0] cnt_q;
  logic       timeout_q;

  // A real response in the same cycle as expiry takes precedence.
  assign abort     = (state_q == StResp) && !data.rvalid && (cnt_q == CntLast);
  assign timeout_o = timeout_q;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == StAddr && data.gnt) begin
        cnt_q <= '0;
      end else if (state_q == StResp && !data.rvalid) begin
        cnt_q <= cnt_q + 10'd1;
      end
      if (abort) begin
        timeout_q <= 1'b1;
      end
    end
  end
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    gnt_hit   = (state_q == StAddr) && data.gnt;
    rsp_hit   = (state_q == StResp) && (data.rvalid || abort);
    rsp_rdata = abort ? 32'hDEAD_BEEF : data.rdata;
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      be_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (m0.req || m1.req) begin
            owner_q <= winner;
            req_q   <= 1'b1;
            state_q <= StAddr;
            if (winner) begin
              we_q    <= m1.we;
              be_q    <= m1.be;
              addr_q  <= m1.addr;
              wdata_q <= m1.wdata;
            end else begin
              we_q    <= m0.we;
              be_q    <= m0.be;
              addr_q  <= m0.addr;
              wdata_q <= m0.wdata;
            end
          end
        end
        StAddr: begin
          if (data.gnt) begin
            req_q   <= 1'b0;
            state_q <= StResp;
          end
        end
        StResp: begin
          if (rsp_hit) begin
            last_owner_q <= owner_q;
            state_q      <= StIdle;
          end
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Memory side is driven only from the holding registers.
  always_comb begin
    data.req   = req_q;
    data.we    = we_q;
    data.be    = be_q;
    data.addr  = addr_q;
    data.wdata = wdata_q;
  end

  always_comb begin
    m0.gnt    = gnt_hit && !owner_q;
    m1.gnt    = gnt_hit && owner_q;
    m0.rvalid = rsp_hit && !owner_q;
    m1.rvalid = rsp_hit && owner_q;
    m0.rdata  = (rsp_hit && !owner_q) ? rsp_rdata : '0;
    m1.rdata  = (rsp_hit && owner_q) ? rsp_rdata : '0;
  end

endmodule

// File: tb/tb_miriscv_data_arb.sv
// Directed bench for miriscv_data_arb; inputs change at posedge+1, outputs sampled at posedge+3.
module tb_miriscv_data_arb;
  logic clk   = 1'b0;
  logic arstn = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  miriscv_data_arb_if m0_if ();
  miriscv_data_arb_if m1_if ();
  miriscv_data_arb_if mem_if ();

`ifdef MIRISCV_DATA_ARB_TIMEOUT_EN
  logic timeout;
`endif

  miriscv_data_arb #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i  (clk),
    .arstn_i(arstn),
    .m0     (m0_if),
    .m1     (m1_if),
    .data   (mem_if)
`ifdef MIRISCV_DATA_ARB_TIMEOUT_EN
    ,
    .timeout_o(timeout)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_if.req = 0; m0_if.we = 0; m0_if.be = '0; m0_if.addr = '0; m0_if.wdata = '0;
    m1_if.req = 0; m1_if.we = 0; m1_if.be = '0; m1_if.addr = '0; m1_if.wdata = '0;
    mem_if.gnt = 0; mem_if.rvalid = 0; mem_if.rdata = '0;
  endtask

  int          n;
  int          both_gnt;
  int          gcnt;
  logic        gseq  [8];
  logic [31:0] gaddr [8];

  initial begin
    idle_inputs();
    // Reset state with memory pushing stray handshakes.
    mem_if.gnt = 1; mem_if.rvalid = 1; mem_if.rdata = 32'h7777_7777;
    #1 arstn = 0;
    #2;
    chk("rst_data_req", mem_if.req, 0);
    chk("rst_data_addr", mem_if.addr, 0);
    chk("rst_data_be", mem_if.be, 0);
    chk("rst_m0_gnt", m0_if.gnt, 0);
    chk("rst_m0_rvalid", m0_if.rvalid, 0);
    chk("rst_m1_rdata", m1_if.rdata, 0);
`ifdef MIRISCV_DATA_ARB_TIMEOUT_EN
    chk("rst_timeout", timeout, 0);
`endif
    cyc();
    arstn = 1;
    idle_inputs();

    // Single m0 read.
    m0_if.req = 1; m0_if.addr = 32'h100; m0_if.be = 4'hF;
    mem_if.rdata = 32'h5555_AAAA;
    #2;
    chk("t1_idle_req", mem_if.req, 0);
    chk("t1_idle_rdata_gated", m0_if.rdata, 0);
    cyc();
    mem_if.gnt = 1;
    #2;
    chk("t1_addr_req", mem_if.req, 1);
    chk("t1_addr", mem_if.addr, 32'h100);
    chk("t1_m0_gnt", m0_if.gnt, 1);
    chk("t1_m1_gnt", m1_if.gnt, 0);
    cyc();
    m0_if.req = 0; mem_if.gnt = 0; mem_if.rvalid = 1; mem_if.rdata = 32'h1234_5678;
    #2;
    chk("t1_resp_req", mem_if.req, 0);
    chk("t1_resp_m0_gnt", m0_if.gnt, 0);
    chk("t1_m0_rvalid", m0_if.rvalid, 1);
    chk("t1_m0_rdata", m0_if.rdata, 32'h1234_5678);
    chk("t1_m1_rvalid", m1_if.rvalid, 0);
    chk("t1_m1_rdata", m1_if.rdata, 0);
    cyc();
    #2;
    chk("t1_stray_rvalid", m0_if.rvalid, 0);
    chk("t1_stray_rdata", m0_if.rdata, 0);
    chk("t1_idle_req2", mem_if.req, 0);

    // Fairness: fresh reset, both request continuously, memory always ready.
    arstn = 0;
    idle_inputs();
    cyc();
    arstn = 1;
    m0_if.req = 1; m0_if.addr = 32'h10; m0_if.be = 4'hF;
    m1_if.req = 1; m1_if.addr = 32'h20; m1_if.be = 4'hF;
    mem_if.gnt = 1; mem_if.rvalid = 1; mem_if.rdata = 32'hA5A5_0000;
    n = 0;
    both_gnt = 0;
    for (int i = 0; i < 12; i++) begin
      #2;
      if (m0_if.gnt && m1_if.gnt) both_gnt++;
      if ((m0_if.gnt || m1_if.gnt) && n < 8) begin
        gseq[n]  = m1_if.gnt;
        gaddr[n] = mem_if.addr;
        n++;
      end
      cyc();
    end
    chk("t2_grant_count", n, 4);
    chk("t2_both_gnt", both_gnt, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_order%0d", i), gseq[i], (i % 2 == 1));
      chk($sformatf("t2_addr%0d", i), gaddr[i], (i % 2 == 1) ? 32'h20 : 32'h10);
    end
    idle_inputs();
    cyc();

    // m1 write with grant withheld three cycles.
    m1_if.req = 1; m1_if.we = 1; m1_if.addr = 32'h200; m1_if.wdata = 32'hCAFE_F00D;
    m1_if.be = 4'b1100;
    cyc();
    gcnt = 0;
    for (int k = 0; k < 4; k++) begin
      mem_if.gnt = (k == 3);
      #2;
      chk($sformatf("t3_req%0d", k), mem_if.req, 1);
      chk($sformatf("t3_addr%0d", k), mem_if.addr, 32'h200);
      chk($sformatf("t3_wdata%0d", k), mem_if.wdata, 32'hCAFE_F00D);
      chk($sformatf("t3_be%0d", k), mem_if.be, 4'b1100);
      chk($sformatf("t3_we%0d", k), mem_if.we, 1);
      chk($sformatf("t3_m1_gnt%0d", k), m1_if.gnt, (k == 3));
      if (m1_if.gnt) gcnt++;
      cyc();
    end
    m1_if.req = 0; m1_if.addr = 32'h300; m1_if.wdata = 32'h1111_1111;
    mem_if.gnt = 1;
    #2;
    chk("t3_resp_req", mem_if.req, 0);
    chk("t3_resp_addr", mem_if.addr, 32'h200);
    chk("t3_resp_wdata", mem_if.wdata, 32'hCAFE_F00D);
    chk("t3_resp_gnt_ignored", m1_if.gnt, 0);
    chk("t3_resp_no_rvalid", m1_if.rvalid, 0);
    if (m1_if.gnt) gcnt++;
    cyc();
    mem_if.gnt = 0; mem_if.rvalid = 1; mem_if.rdata = 32'h0;
    #2;
    chk("t3_m1_rvalid", m1_if.rvalid, 1);
    chk("t3_m0_rvalid", m0_if.rvalid, 0);
    chk("t3_resp_addr2", mem_if.addr, 32'h200);
    chk("t3_gnt_pulses", gcnt, 1);
    cyc();
    mem_if.rvalid = 0;
    #2;
    chk("t3_idle_addr", mem_if.addr, 32'h200);
    chk("t3_idle_req", mem_if.req, 0);

    // Reset asserted during ADDR.
    m0_if.req = 1; m0_if.addr = 32'h400; m0_if.be = 4'hF;
    cyc();
    #2;
    chk("t4_addr_req", mem_if.req, 1);
    mem_if.gnt = 1; mem_if.rvalid = 1; mem_if.rdata = 32'hFFFF_FFFF;
    #1 arstn = 0;
    #1;
    chk("t4_rst_req", mem_if.req, 0);
    chk("t4_rst_addr", mem_if.addr, 0);
    chk("t4_rst_be", mem_if.be, 0);
    chk("t4_rst_m0_gnt", m0_if.gnt, 0);
    chk("t4_rst_m0_rvalid", m0_if.rvalid, 0);
    m0_if.req = 0;
    cyc();
    arstn = 1;
    for (int j = 0; j < 3; j++) begin
      #2;
      chk($sformatf("t4_post_req%0d", j), mem_if.req, 0);
      chk($sformatf("t4_post_evt%0d", j),
          {m0_if.gnt, m0_if.rvalid, m1_if.gnt, m1_if.rvalid}, 4'b0000);
      cyc();
    end
    m1_if.req = 1; m1_if.addr = 32'h500; m1_if.we = 0;
    mem_if.rdata = 32'h0BAD_CAFE;
    cyc();
    #2;
    chk("t4_new_req", mem_if.req, 1);
    chk("t4_new_addr", mem_if.addr, 32'h500);
    chk("t4_new_m1_gnt", m1_if.gnt, 1);
    m1_if.req = 0;
    cyc();
    #2;
    chk("t4_new_m1_rvalid", m1_if.rvalid, 1);
    chk("t4_new_m1_rdata", m1_if.rdata, 32'h0BAD_CAFE);
    chk("t4_new_m0_rdata", m0_if.rdata, 0);

`ifdef MIRISCV_DATA_ARB_TIMEOUT_EN
    // Memory never responds; abort in the fourth RESP cycle.
    cyc();
    idle_inputs();
    m0_if.req = 1; m0_if.addr = 32'h600; m0_if.be = 4'hF;
    mem_if.gnt = 1;
    cyc();
    #2;
    chk("t5_m0_gnt", m0_if.gnt, 1);
    chk("t5_timeout_pre", timeout, 0);
    m0_if.req = 0; mem_if.gnt = 0;
    for (int r = 1; r <= 4; r++) begin
      cyc();
      #2;
      chk($sformatf("t5_rvalid%0d", r), m0_if.rvalid, (r == 4));
      chk($sformatf("t5_rdata%0d", r), m0_if.rdata, (r == 4) ? 32'hDEAD_BEEF : 32'h0);
    end
    cyc();
    #2;
    chk("t5_timeout_set", timeout, 1);
    chk("t5_idle_rvalid", m0_if.rvalid, 0);
    m1_if.req = 1; m1_if.addr = 32'h700;
    mem_if.gnt = 1; mem_if.rvalid = 1; mem_if.rdata = 32'h600D_600D;
    cyc();
    #2;
    chk("t5_next_gnt", m1_if.gnt, 1);
    m1_if.req = 0;
    cyc();
    #2;
    chk("t5_next_rvalid", m1_if.rvalid, 1);
    chk("t5_next_rdata", m1_if.rdata, 32'h600D_600D);
    chk("t5_timeout_sticky", timeout, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
